gate_arb: RTL and testbench

GATE_ARB -- requirements
Module: gate_arb

---
 rtl/gate_arb_pkg.sv | 14 +
 rtl/gate_fn.sv | 16 +
 rtl/gate_arb.sv | 120 ++++++++++++
 tb/tb_gate_arb.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/gate_arb_pkg.sv
// rtl/gate_arb_pkg.sv - shared op encodings, FSM state type and counter width for gate_arb
package gate_arb_pkg;

  localparam logic OP_XNOR   = 1'b0;
  localparam logic OP_ANDXOR = 1'b1;

  localparam int CNT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

endpackage

// File: rtl/gate_fn.sv
// rtl/gate_fn.sv - shared combinational gate function unit (XNOR or ANDXOR)
module gate_fn
  import gate_arb_pkg::*;
(
  input  logic op,
  input  logic a,
  input  logic b,
  output logic y
);

  always_comb begin
    y = a ~^ b;
    if (op == OP_ANDXOR) y = (a ^ b) & a;
  end

endmodule

// File: rtl/gate_arb.sv
// rtl/gate_arb.sv - round-robin arbiter sharing one gate_fn, one response held at a time
// Optional per-requester grant counters on output grant_cnt when GATE_ARB_STATS_EN is defined.
module gate_arb
  import gate_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_a,
  input  logic [N_REQ-1:0]           req_b,
  input  logic [N_REQ-1:0]           req_op,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       rsp_valid,
  output logic                       rsp_y,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  input  logic                       rsp_ready
`ifdef GATE_ARB_STATS_EN
  ,output logic [N_REQ*CNT_W-1:0]    grant_cnt
`endif
);

  localparam int ID_W = $clog2(N_REQ);

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic            rsp_y_q, rsp_y_d;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_found;
  logic            window;
  logic            accept;
  logic            fn_y;
  int              idx;

  // Search starts at ptr and wraps; idx stays below N_REQ so the slice is exact.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!gnt_found && req_valid[idx[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_id    = idx[ID_W-1:0];
      end
    end
  end

  assign window = !reset && ((state_q == IDLE) || rsp_ready);
  assign accept = window && gnt_found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_id] = 1'b1;
  end

  gate_fn u_gate_fn (
    .op (req_op[gnt_id]),
    .a  (req_a[gnt_id]),
    .b  (req_b[gnt_id]),
    .y  (fn_y)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rsp_id_d = rsp_id_q;
    rsp_y_d  = rsp_y_q;
    if (accept) begin
      state_d  = RESP;
      rsp_id_d = gnt_id;
      rsp_y_d  = fn_y;
      ptr_d    = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
    end else if (state_q == RESP && rsp_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      rsp_id_q <= '0;
      rsp_y_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rsp_id_q <= rsp_id_d;
      rsp_y_q  <= rsp_y_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_y     = rsp_y_q;
  assign rsp_id    = rsp_id_q;

`ifdef GATE_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [N_REQ];

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (reset) begin
        cnt_q[i] <= '0;
      end else if (accept && gnt_id == ID_W'(i) && cnt_q[i] != '1) begin
        cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < N_REQ; i++) grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_gate_arb.sv
// tb/tb_gate_arb.sv - directed self-checking bench for gate_arb
module tb_gate_arb;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_valid, req_a, req_b, req_op, req_ready;
  logic       rsp_valid, rsp_y, rsp_ready;
  logic [1:0] rsp_id;
`ifdef GATE_ARB_STATS_EN
  logic [63:0] grant_cnt;
`endif

  int total = 0;
  int bad   = 0;

  gate_arb #(.N_REQ(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_y     (rsp_y),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready)
`ifdef GATE_ARB_STATS_EN
    ,.grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] fn_exp;
  logic [2:0] vec;
  int         rr_seq [6];

  initial begin
    fn_exp    = 8'b0100_1001;
    rr_seq    = '{0, 1, 2, 3, 0, 1};
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // reset mid-RESP with the response stalled
    req_valid = 4'b0010;
    #1 chk("first_grant_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("pre_rst_valid", 32'(rsp_valid), 32'h1);
    chk("pre_rst_id", 32'(rsp_id), 32'h1);
    chk("pre_rst_y", 32'(rsp_y), 32'h1);
    chk("pre_rst_ptr", 32'(dut.ptr_q), 32'h2);
    req_valid = 4'b1111;
    reset     = 1'b1;
    #1 chk("ready_in_reset", 32'(req_ready), 32'h0);
    tick();
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_y", 32'(rsp_y), 32'h0);
    chk("rst_id", 32'(rsp_id), 32'h0);
    chk("rst_ptr", 32'(dut.ptr_q), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    reset     = 1'b0;
    req_valid = 4'b0000;
    tick();

    // function table through requester 0 back to back
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    for (int v = 0; v < 8; v++) begin
      vec       = 3'(v);
      req_op[0] = vec[2];
      req_a[0]  = vec[1];
      req_b[0]  = vec[0];
      #1 chk("fn_ready", 32'(req_ready), 32'h1);
      tick();
      chk("fn_valid", 32'(rsp_valid), 32'h1);
      chk("fn_id", 32'(rsp_id), 32'h0);
      chk($sformatf("fn_y_%0d", v), 32'(rsp_y), 32'(fn_exp[v]));
    end

    // ptr=1 with only requester 0 valid, then an empty cycle
    chk("skip_ptr_before", 32'(dut.ptr_q), 32'h1);
    req_a = '0;
    req_b = '0;
    req_op = '0;
    #1 chk("skip_ready", 32'(req_ready), 32'h1);
    tick();
    chk("skip_id", 32'(rsp_id), 32'h0);
    chk("skip_ptr", 32'(dut.ptr_q), 32'h1);
    req_valid = 4'b0000;
    #1 chk("idle_ready", 32'(req_ready), 32'h0);
    tick();
    chk("hold_ptr", 32'(dut.ptr_q), 32'h1);
    chk("hold_idle", 32'(rsp_valid), 32'h0);

    reset = 1'b1;
    tick();
    reset = 1'b0;

    // round-robin wrap with every requester valid
    req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      #1 chk($sformatf("rr_ready_%0d", i), 32'(req_ready), 32'h1 << rr_seq[i]);
      if (i > 0) chk($sformatf("rr_id_%0d", i), 32'(rsp_id), 32'(rr_seq[i-1]));
      tick();
    end
    chk("rr_id_last", 32'(rsp_id), 32'h1);
    chk("rr_ptr", 32'(dut.ptr_q), 32'h2);

    // backpressure after a grant to requester 2
    req_valid = 4'b1110;
    req_op    = 4'b1100;
    req_a     = 4'b0100;
    req_b     = 4'b1000;
    #1 chk("bp_grant2", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b1010;
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp_ready_%0d", c), 32'(req_ready), 32'h0);
      chk($sformatf("bp_valid_%0d", c), 32'(rsp_valid), 32'h1);
      chk($sformatf("bp_id_%0d", c), 32'(rsp_id), 32'h2);
      chk($sformatf("bp_y_%0d", c), 32'(rsp_y), 32'h1);
      tick();
    end
    rsp_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(req_ready), 32'h8);
    tick();
    chk("bp_id3", 32'(rsp_id), 32'h3);
    chk("bp_y3", 32'(rsp_y), 32'h0);
    req_valid = 4'b0000;
    tick();
    chk("bp_idle", 32'(rsp_valid), 32'h0);

`ifdef GATE_ARB_STATS_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("cnt_rst", 32'(grant_cnt[31:16]), 32'h0);
    dut.cnt_q[1] = 16'hFFFE;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    tick();
    tick();
    tick();
    req_valid = 4'b0000;
    #1 chk("cnt_sat", 32'(grant_cnt[31:16]), 32'hFFFF);
    chk("cnt_other", 32'(grant_cnt[15:0]), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
